// File: rtl/pipeline_stall_ctrl_if.sv
// pipeline_stall_ctrl_if
// Groups the data-cache handshake and pipeline control signals that pass
// between the pipeline datapath (master) and the stall/flush controller
// (slave). Signal names keep the controller's point of view: *_i are driven
// by the pipeline side, *_o are driven by the controller.
//   mem_req_i     MEM-stage instruction is a load/store
//   dcache_ack_i  data cache finished the current access
//   hazard_i      load-use hazard from the hazard detector
//   branch_i      taken branch resolved in ID
//   clr_cnt_i     synchronous clear of the performance counters
//   dcache_req_o  access request to the data cache
//   PCWrite_o     PC update enable
//   Stall_o       hold IF/ID
//   NoOp_o        bubble into ID/EX
//   Flush_o       flush IF/ID
//   Freeze_o      hold ID/EX, EX/MEM, MEM/WB
//   err_o         sticky miss-timeout / handshake-violation flag
//   stall_cnt_o   frozen-cycle counter
//   bubble_cnt_o  load-use bubble counter
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             mem_req_i;
  logic             dcache_ack_i;
  logic             hazard_i;
  logic             branch_i;
  logic             clr_cnt_i;
  logic             dcache_req_o;
  logic             PCWrite_o;
  logic             Stall_o;
  logic             NoOp_o;
  logic             Flush_o;
  logic             Freeze_o;
  logic             err_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] bubble_cnt_o;

  // Controller side
  modport slave (
    input  mem_req_i, dcache_ack_i, hazard_i, branch_i, clr_cnt_i,
    output dcache_req_o, PCWrite_o, Stall_o, NoOp_o, Flush_o, Freeze_o,
           err_o, stall_cnt_o, bubble_cnt_o
  );

  // Pipeline / datapath side
  modport master (
    output mem_req_i, dcache_ack_i, hazard_i, branch_i, clr_cnt_i,
    input  dcache_req_o, PCWrite_o, Stall_o, NoOp_o, Flush_o, Freeze_o,
           err_o, stall_cnt_o, bubble_cnt_o
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
// Central stall/flush controller for the 5-stage pipeline with data cache.
// Sequences the MEM-stage data-cache handshake, freezes the whole pipeline
// while a miss is outstanding, and otherwise forwards load-use bubbles and
// branch flushes. Keeps saturating stall/bubble counters and a sticky
// miss-timeout / handshake-violation error flag.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-low reset
//   bus    pipeline_stall_ctrl_if.slave (handshake + pipeline controls)
module pipeline_stall_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  pipeline_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1
  } state_t;

  // Wide enough for the largest legal TIMEOUT (1023)
  localparam int               WAIT_W    = 10;
  localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    bubble_cnt_q, bubble_cnt_d;
  logic                freeze;
  logic                noop;

  // Pipeline controls are purely combinational so a miss or hazard acts in
  // the same cycle it is seen. A miss freeze outranks everything: the
  // instructions stay in place and any hazard/branch re-presents next cycle.
  // A hazard defers a branch until its operands are ready.
  always_comb begin
    freeze = bus.mem_req_i & ~bus.dcache_ack_i;
    noop   = ~freeze & bus.hazard_i;

    bus.dcache_req_o = bus.mem_req_i;
    bus.Freeze_o     = freeze;
    bus.Stall_o      = freeze | bus.hazard_i;
    bus.PCWrite_o    = ~freeze & ~bus.hazard_i;
    bus.NoOp_o       = noop;
    bus.Flush_o      = ~freeze & ~bus.hazard_i & bus.branch_i;

    bus.err_o        = err_q;
    bus.stall_cnt_o  = stall_cnt_q;
    bus.bubble_cnt_o = bubble_cnt_q;
  end

  // Next-state logic for the handshake FSM, the miss wait counter and the
  // sticky error. Dropping the request while waiting is a protocol
  // violation: flag it and fall back to RUN. A timeout only flags the error;
  // the FSM keeps waiting for the ack.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      RUN: begin
        if (freeze) begin
          state_d = WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      WAIT: begin
        if (!bus.mem_req_i) begin
          err_d   = 1'b1;
          state_d = RUN;
          wait_d  = '0;
        end else if (bus.dcache_ack_i) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q < TIMEOUT_C) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
    if ((state_d == WAIT) && (wait_d == TIMEOUT_C)) begin
      err_d = 1'b1;
    end
  end

  // Saturating performance counters; a clear wins over an increment.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (bus.clr_cnt_i) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (freeze && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (noop && (bubble_cnt_q != CNT_MAX)) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  // All registered state, cleared asynchronously by reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= RUN;
      wait_q       <= '0;
      err_q        <= 1'b0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      err_q        <= err_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall/flush controller for the 5-stage RISC-V pipeline with data cache. Sequences the data-cache access handshake for the MEM stage, freezes the whole pipeline while a miss is outstanding, and otherwise forwards load-use bubbles and branch flushes. Also keeps saturating stall/bubble performance counters and a sticky miss-timeout error flag. Sits beside the load-use hazard detector and drives the PC and all pipeline-register write/flush controls.

## Interface
- CNT_W, 32: width of performance counters.
- TIMEOUT, 64: WAIT cycles before err_o is set; legal range 1..1023.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- mem_req_i  in  1  instruction in MEM stage is a load/store.
- dcache_ack_i  in  1  data cache completed current access (may be same cycle as request).
- hazard_i  in  1  load-use hazard from the hazard detector.
- branch_i  in  1  taken branch resolved in ID.
- clr_cnt_i  in  1  synchronous clear of both counters.
- dcache_req_o  out  1  access request to data cache.
- PCWrite_o  out  1  PC update enable.
- Stall_o  out  1  hold IF/ID.
- NoOp_o  out  1  insert bubble into ID/EX.
- Flush_o  out  1  flush IF/ID.
- Freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB.
- err_o  out  1  sticky: miss timeout or handshake violation.
- stall_cnt_o  out  CNT_W  cycles with Freeze_o=1.
- bubble_cnt_o  out  CNT_W  bubbles inserted by load-use.

## Operation
- States: RUN, WAIT (2-bit encoding, reset RUN).
- dcache_req_o = mem_req_i in both states (combinational); a request is held high for its whole lifetime.
- freeze = mem_req_i & ~dcache_ack_i.
- RUN: mem_req_i & dcache_ack_i -> hit, no stall, stay RUN. mem_req_i & ~dcache_ack_i -> freeze, go WAIT, wait counter := 1.
- WAIT: dcache_ack_i -> freeze released same cycle, go RUN, wait counter := 0. No ack -> stay WAIT, wait counter +1 (saturate at TIMEOUT). mem_req_i=0 in WAIT is a violation: set err_o, go RUN.
- err_o set when wait counter reaches TIMEOUT while in WAIT; FSM stays in WAIT (no abort). Cleared only by reset.
- Control priority, combinational each cycle:
  - freeze: PCWrite_o=0, Stall_o=1, Freeze_o=1, NoOp_o=0, Flush_o=0 (hazard/branch ignored; instructions remain in place and re-present next cycle).
  - else hazard_i: PCWrite_o=0, Stall_o=1, NoOp_o=1, Flush_o=0 (branch deferred; it is re-evaluated once operands are ready).
  - else branch_i: PCWrite_o=1, Flush_o=1, others 0.
  - else: PCWrite_o=1, others 0.
- Counters: stall_cnt_o +1 per cycle with freeze; bubble_cnt_o +1 per cycle with NoOp_o=1. Both saturate at all-ones. clr_cnt_i has priority over increment.

## Timing
- Reset (async, rst_i=0): state RUN, wait counter 0, err_o 0, both counters 0. Combinational outputs follow inputs: with mem_req_i=0, hazard_i=0, branch_i=0 -> PCWrite_o=1, others 0, dcache_req_o=0.
- Reset asserted mid-WAIT: state returns to RUN immediately; dcache_req_o still follows mem_req_i.
- Hit: zero stall cycles. Miss with ack after N cycles of request: Freeze_o high exactly N cycles, stall_cnt_o +N.
- Control outputs have zero latency from inputs; counters, err_o, and state update on rising clk_i.
- err_o rises on the edge where wait counter reaches TIMEOUT, i.e. after TIMEOUT frozen cycles without ack.

## Test plan
- Reset, idle inputs -> PCWrite_o=1, all else 0, counters 0; reset while in WAIT -> state RUN, err_o=0.
- mem_req_i=1 with dcache_ack_i=1 same cycle -> no freeze, stall_cnt_o stays 0.
- mem_req_i=1, ack after 5 cycles -> Freeze_o/Stall_o high 5 cycles, PCWrite_o low, stall_cnt_o=5, state RUN afterwards.
- hazard_i=1 and branch_i=1 together, no miss -> NoOp_o=1, Flush_o=0, bubble_cnt_o +1; hazard+branch during miss -> only freeze outputs, bubble_cnt_o unchanged.
- TIMEOUT=4, no ack for 6 cycles -> err_o rises after 4th cycle, stays 1 after ack; mem_req_i dropped in WAIT -> err_o=1, state RUN.
- CNT_W=4, 20 frozen cycles -> stall_cnt_o saturates at 15; clr_cnt_i pulse -> 0 next edge.
